lane_traffic_engine: RTL and testbench
======================================

// Module: lane_traffic_engine
// PURPOSE
//  Parametrised road-traffic core for the frog game: N_LANES car lanes with
//  alternating direction, per-lane move period, level-scaled step, screen
//  wrap-around, player/car collision detection and a post-hit freeze.
//  Sits between the VGA timing (frame_tick) and player logic; feeds the
//  packed car_x bus to colour generation.
// PARAMETERS
//  N_LANES     6    number of road lanes (1..15)
//  X_W         10   pixel coordinate width
//  SCREEN_W    640  horizontal wrap modulus in pixels
//  CAR_W       32   car width in pixels
//  PLAYER_W    16   player width in pixels
//  START_STEP  100  reset spacing: lane i starts at (i*START_STEP) % SCREEN_W
//  MAX_LEVEL   7    level saturation value; LVL_W = clog2(MAX_LEVEL+1)
//  HIT_FRAMES  3    frames frozen after a collision (>=1)
// PORTS
//  CLK          in   1            system clock (25 MHz)
//  RST          in   1            async active-high reset
//  frame_tick   in   1            1-cycle pulse per video frame
//  game_reset   in   1            sync: reload reset values of all state
//  level_up     in   1            1-cycle pulse: player reached far bank
//  player_lane  in   4            0 = safe bank; 1..N_LANES = road lane (lane index+1)
//  player_x     in   X_W          player left edge
//  car_x        out  N_LANES*X_W  lane i left edge at [i*X_W +: X_W]
//  collision    out  1            1-cycle pulse on hit
//  frozen       out  1            high while in HIT
//  level        out  LVL_W        current level
// BEHAVIOUR
//  - RST (async) and game_reset (sync, same values): car_x[i]=(i*START_STEP)%SCREEN_W,
//    div_cnt[i]=0, level=0, hit_cnt=0, collision=0, frozen=0, state=RUN.
//  - Lane i: direction right if i even, left if i odd; period P_i=(i%3)+1 ticks;
//    step S=level+1 pixels.
//  - FSM RUN/CHECK/HIT.
//    RUN: frame_tick -> per lane: if div_cnt[i]==P_i-1 move lane, div_cnt[i]<=0,
//      else div_cnt[i]++; next state CHECK. New car_x visible the cycle after tick.
//    CHECK (exactly 1 cycle): hit if any lane i has player_lane==i+1 and
//      player_x+PLAYER_W > car_x[i] and player_x < car_x[i]+CAR_W (X_W+1-bit
//      compare, no wrap-aware overlap). Hit -> collision=1 next cycle only,
//      hit_cnt<=HIT_FRAMES, state HIT, frozen=1. No hit -> RUN.
//    HIT: lanes and div_cnt frozen; each frame_tick decrements hit_cnt; on the
//      tick where hit_cnt==1 -> RUN, frozen=0 (that tick does not move lanes).
//  - frame_tick during CHECK is ignored (ticks are >=800 cycles apart).
//  - Wrap right: x+S>=SCREEN_W -> x+S-SCREEN_W, else x+S.
//    Wrap left:  x<S -> x+SCREEN_W-S, else x-S. car_x always < SCREEN_W.
//  - level_up: level<=min(level+1,MAX_LEVEL) in any state; new step applies from
//    next move. Coincident with hit detection: both take effect.
//  - game_reset has priority over frame_tick and level_up in the same cycle.
//  - RST mid-HIT or mid-CHECK: immediate return to reset values, no collision pulse.
// TESTING
//  1 Release RST -> car_x = 0,100,200,300,400,500; level=0, frozen=0, collision=0.
//  2 player_lane=0, 2 ticks -> lane0=2 (right), lane1=99 (left, P=2), lane2=200 (P=3).
//  3 level_up x4 (S=5), player_lane=0, 128 ticks -> lane0 wraps back to 0;
//    level_up x10 -> level saturates at 7.
//  4 Lane1 wrap-left: S=1, 202 ticks from reset -> lane1 = 639.
//  5 player_lane=1, player_x=10, 1 tick (lane0=1) -> collision 1 cycle after CHECK,
//    frozen=1; lanes unchanged for 3 ticks; frozen=0 on 3rd tick; 4th tick moves.
//  6 Assert RST during HIT -> frozen=0 and reset positions same cycle; game_reset
//    together with level_up -> level=0.

Source files
------------

// File: rtl/lane_traffic_engine.sv
`default_nettype none
// ============================================================================
// Module      : lane_traffic_engine
// Description : Car-lane traffic core for the frog game. Moves N_LANES cars with
//               wrap-around, detects player/car overlap and freezes after a hit.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_traffic_engine #(
   parameter int N_LANES    = 6,
   parameter int X_W        = 10,
   parameter int SCREEN_W   = 640,
   parameter int CAR_W      = 32,
   parameter int PLAYER_W   = 16,
   parameter int START_STEP = 100,
   parameter int MAX_LEVEL  = 7,
   parameter int HIT_FRAMES = 3,
   parameter int LVL_W      = $clog2(MAX_LEVEL + 1)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   frame_tick,
   input  logic                   game_reset,
   input  logic                   level_up,
   input  logic [3:0]             player_lane,
   input  logic [X_W-1:0]         player_x,
   output logic [N_LANES*X_W-1:0] car_x,
   output logic                   collision,
   output logic                   frozen,
   output logic [LVL_W-1:0]       level
);

   localparam int HC_W = $clog2(HIT_FRAMES + 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_CHECK = 2'd1,
      S_HIT   = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic [N_LANES-1:0][X_W-1:0]  car_x_q, car_x_d;
   logic [N_LANES-1:0][1:0]      div_cnt_q, div_cnt_d;
   logic [LVL_W-1:0]             level_q, level_d;
   logic [HC_W-1:0]              hit_cnt_q, hit_cnt_d;
   logic                         collision_q, collision_d;
   logic                         w_hit;
   logic [X_W-1:0]               w_step;

   function automatic logic [X_W-1:0] init_x(input int i);
      return X_W'((i * START_STEP) % SCREEN_W);
   endfunction

   // Lane period is (i%3)+1 ticks, so the divider terminal count is i%3.
   function automatic logic [1:0] div_last(input int i);
      return 2'(i % 3);
   endfunction

   function automatic logic [X_W-1:0] move_x(input logic [X_W-1:0] x,
                                             input logic [X_W-1:0] s,
                                             input logic           right);
      logic [X_W:0] sum;
      if (right) begin
         sum = {1'b0, x} + {1'b0, s};
         if (sum >= (X_W+1)'(SCREEN_W))
            sum = sum - (X_W+1)'(SCREEN_W);
      end else begin
         if (x < s)
            sum = {1'b0, x} + (X_W+1)'(SCREEN_W) - {1'b0, s};
         else
            sum = {1'b0, x} - {1'b0, s};
      end
      return X_W'(sum);
   endfunction

   assign w_step = X_W'(level_q) + X_W'(1);

   // Plain unsigned overlap on X_W+1 bits; a car straddling the wrap edge is
   // only seen at its unwrapped position.
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
         if ((player_lane == 4'(i + 1)) &&
             (({1'b0, player_x} + (X_W+1)'(PLAYER_W)) > {1'b0, car_x_q[i]}) &&
             ({1'b0, player_x} < ({1'b0, car_x_q[i]} + (X_W+1)'(CAR_W))))
            w_hit = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      car_x_d     = car_x_q;
      div_cnt_d   = div_cnt_q;
      level_d     = level_q;
      hit_cnt_d   = hit_cnt_q;
      collision_d = 1'b0;

      if (game_reset) begin
         state_d   = S_RUN;
         level_d   = '0;
         hit_cnt_d = '0;
         for (int i = 0; i < N_LANES; i++) begin
            car_x_d[i]   = init_x(i);
            div_cnt_d[i] = 2'd0;
         end
      end else begin
         if (level_up && (level_q != LVL_W'(MAX_LEVEL)))
            level_d = level_q + LVL_W'(1);

         unique case (state_q)
            S_RUN: begin
               if (frame_tick) begin
                  for (int i = 0; i < N_LANES; i++) begin
                     if (div_cnt_q[i] == div_last(i)) begin
                        car_x_d[i]   = move_x(car_x_q[i], w_step, (i % 2) == 0);
                        div_cnt_d[i] = 2'd0;
                     end else begin
                        div_cnt_d[i] = div_cnt_q[i] + 2'd1;
                     end
                  end
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_hit) begin
                  collision_d = 1'b1;
                  hit_cnt_d   = HC_W'(HIT_FRAMES);
                  state_d     = S_HIT;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_HIT: begin
               if (frame_tick) begin
                  hit_cnt_d = hit_cnt_q - HC_W'(1);
                  if (hit_cnt_q == HC_W'(1))
                     state_d = S_RUN;
               end
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_RUN;
         level_q     <= '0;
         hit_cnt_q   <= '0;
         collision_q <= 1'b0;
         for (int i = 0; i < N_LANES; i++) begin
            car_x_q[i]   <= init_x(i);
            div_cnt_q[i] <= 2'd0;
         end
      end else begin
         state_q     <= state_d;
         car_x_q     <= car_x_d;
         div_cnt_q   <= div_cnt_d;
         level_q     <= level_d;
         hit_cnt_q   <= hit_cnt_d;
         collision_q <= collision_d;
      end
   end

   assign car_x     = car_x_q;
   assign collision = collision_q;
   assign frozen    = (state_q == S_HIT);
   assign level     = level_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_traffic_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_traffic_engine
// Description : Directed self-checking bench for lane_traffic_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_traffic_engine;

   localparam int N_LANES = 6;
   localparam int X_W     = 10;
   localparam int LVL_W   = 3;

   logic                   CLK = 1'b0;
   logic                   RST = 1'b1;
   logic                   frame_tick = 1'b0;
   logic                   game_reset = 1'b0;
   logic                   level_up = 1'b0;
   logic [3:0]             player_lane = 4'd0;
   logic [X_W-1:0]         player_x = '0;
   logic [N_LANES*X_W-1:0] car_x;
   logic                   collision;
   logic                   frozen;
   logic [LVL_W-1:0]       level;

   int checks = 0;
   int errors = 0;

   lane_traffic_engine dut (
      .CLK         (CLK),
      .RST         (RST),
      .frame_tick  (frame_tick),
      .game_reset  (game_reset),
      .level_up    (level_up),
      .player_lane (player_lane),
      .player_x    (player_x),
      .car_x       (car_x),
      .collision   (collision),
      .frozen      (frozen),
      .level       (level)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int lane(input int i);
      return int'(car_x[i*X_W +: X_W]);
   endfunction

   task automatic chk_lanes(input string tag, input int exp [N_LANES]);
      for (int i = 0; i < N_LANES; i++)
         chk($sformatf("%s_lane%0d", tag, i), lane(i), exp[i]);
   endtask

   task automatic tick();
      @(negedge CLK) frame_tick = 1'b1;
      @(negedge CLK) frame_tick = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic pulse_level_up();
      @(negedge CLK) level_up = 1'b1;
      @(negedge CLK) level_up = 1'b0;
   endtask

   task automatic pulse_game_reset();
      @(negedge CLK) game_reset = 1'b1;
      @(negedge CLK) game_reset = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk_lanes("reset", '{0, 100, 200, 300, 400, 500});
      chk("reset_level", int'(level), 0);
      chk("reset_frozen", int'(frozen), 0);
      chk("reset_collision", int'(collision), 0);

      // Two ticks at step 1, player on safe bank
      tick();
      chk("tick1_lane0", lane(0), 1);
      tick();
      chk_lanes("tick2", '{2, 99, 200, 298, 401, 500});
      chk("tick2_collision", int'(collision), 0);

      // Step 5 over 128 ticks: lane0 travels exactly one screen width
      pulse_game_reset();
      repeat (4) pulse_level_up();
      chk("level4", int'(level), 4);
      repeat (128) tick();
      chk_lanes("s5_128", '{0, 420, 410, 300, 80, 290});
      repeat (10) pulse_level_up();
      chk("level_sat", int'(level), 7);

      // Left wrap of lane1 at step 1
      pulse_game_reset();
      chk("greset_level", int'(level), 0);
      repeat (202) tick();
      chk("wrap_lane0", lane(0), 202);
      chk("wrap_lane1", lane(1), 639);
      chk("wrap_lane2", lane(2), 267);
      chk("wrap_lane3", lane(3), 98);

      // game_reset wins over a coincident frame_tick
      @(negedge CLK) begin game_reset = 1'b1; frame_tick = 1'b1; end
      @(negedge CLK) begin game_reset = 1'b0; frame_tick = 1'b0; end
      repeat (2) @(negedge CLK);
      chk_lanes("greset_tick", '{0, 100, 200, 300, 400, 500});

      // Collision on lane 0 and the freeze that follows
      player_lane = 4'd1;
      player_x    = 10'd10;
      @(negedge CLK) frame_tick = 1'b1;
      @(negedge CLK) frame_tick = 1'b0;
      chk("hit_lane0_moved", lane(0), 1);
      chk("hit_check_coll", int'(collision), 0);
      chk("hit_check_frozen", int'(frozen), 0);
      @(negedge CLK);
      chk("hit_collision", int'(collision), 1);
      chk("hit_frozen", int'(frozen), 1);
      @(negedge CLK);
      chk("hit_coll_pulse", int'(collision), 0);
      tick();
      chk("frz1_frozen", int'(frozen), 1);
      chk("frz1_lane0", lane(0), 1);
      tick();
      chk("frz2_frozen", int'(frozen), 1);
      chk("frz2_lane1", lane(1), 100);
      tick();
      chk("frz3_frozen", int'(frozen), 0);
      chk("frz3_lane0", lane(0), 1);
      @(negedge CLK) frame_tick = 1'b1;
      @(negedge CLK) frame_tick = 1'b0;
      chk("resume_lane0", lane(0), 2);
      chk("resume_lane1", lane(1), 99);
      @(negedge CLK);
      chk("rehit_collision", int'(collision), 1);
      @(negedge CLK);
      chk("rehit_frozen", int'(frozen), 1);

      // Asynchronous reset in the middle of HIT
      #2 RST = 1'b1;
      #1;
      chk("arst_frozen", int'(frozen), 0);
      chk("arst_collision", int'(collision), 0);
      chk("arst_lane0", lane(0), 0);
      chk("arst_lane1", lane(1), 100);
      @(negedge CLK) RST = 1'b0;
      player_lane = 4'd0;

      // game_reset beats a coincident level_up
      repeat (2) pulse_level_up();
      chk("pre_greset_level", int'(level), 2);
      @(negedge CLK) begin game_reset = 1'b1; level_up = 1'b1; end
      @(negedge CLK) begin game_reset = 1'b0; level_up = 1'b0; end
      chk("greset_lvlup_level", int'(level), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
